// File: rtl/bias_add_13_pkg.sv
// bias_add_13_pkg
//   Shared definitions for the layer-13 bias-add stage: data widths, channel and
//   pixel geometry, fixed-point shift amounts, FSM state encoding and the
//   narrowing function that converts the rescaled sum to the output width.
//   Optional feature macro: BIAS_ADD_13_SAT_EN
//     defined   -> narrowing saturates to the signed OUT_W range
//     undefined -> narrowing keeps the low OUT_W bits (two's-complement wrap)
package bias_add_13_pkg;

  localparam int COEFF_W  = 16;
  localparam int ACC_W    = 32;
  localparam int OUT_W    = 16;
  localparam int N_CH     = 16;
  localparam int N_PIX    = 64;
  localparam int BIAS_SHL = 8;
  localparam int OUT_SHR  = 8;

  localparam int CH_W  = $clog2(N_CH);
  localparam int PIX_W = $clog2(N_PIX);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // The rescaled sum is carried in ACC_W+1 bits so the bias add can never
  // overflow; this reduces it to the OUT_W-bit result word.
  function automatic logic [OUT_W-1:0] narrow_result(input logic signed [ACC_W:0] r);
`ifdef BIAS_ADD_13_SAT_EN
    logic signed [ACC_W:0] max_v;
    logic signed [ACC_W:0] min_v;
    max_v = $signed({{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
    min_v = $signed({{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}});
    if (r > max_v) begin
      return max_v[OUT_W-1:0];
    end else if (r < min_v) begin
      return min_v[OUT_W-1:0];
    end else begin
      return r[OUT_W-1:0];
    end
`else
    return r[OUT_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/bias_add_13_regfile.sv
// bias_regfile_13
//   N_CH x COEFF_W storage for the per-channel bias coefficients of one frame.
//   Ports:
//     clk    in   clock
//     we     in   write enable (synchronous)
//     waddr  in   write channel index
//     wdata  in   bias coefficient to store
//     raddr  in   read channel index
//     rdata  out  coefficient at raddr (combinational read)
//   Contents are fully rewritten at the start of every frame, so the array
//   carries no reset.
module bias_regfile_13
  import bias_add_13_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [CH_W-1:0]    waddr,
  input  logic [COEFF_W-1:0] wdata,
  input  logic [CH_W-1:0]    raddr,
  output logic [COEFF_W-1:0] rdata
);

  logic [COEFF_W-1:0] mem [N_CH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bias_add_13.sv
// bias_add_13
//   Layer-13 bias-add stage. Each frame it first loads N_CH bias coefficients
//   from the bias FIFO, then adds the matching bias to every accumulator word
//   (channel-fastest order), rescales, narrows and pushes the result to the
//   output FIFO. After the last word of the frame is pushed it pulses
//   frame_done and returns to loading biases for the next frame.
//   Optional feature macro: BIAS_ADD_13_SAT_EN (saturating narrow when defined).
//   Ports:
//     ap_clk, ap_rst_n            clock, asynchronous active-low reset
//     acc_V_dout/empty_n/read     accumulator FIFO (signed ACC_W data)
//     bias_V_dout/empty_n/read    bias FIFO (signed COEFF_W data)
//     output_V_din/full_n/write   result FIFO (signed OUT_W data)
//     frame_done                  pulse with the final push of a frame
module bias_add_13
  import bias_add_13_pkg::*;
(
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [ACC_W-1:0]   acc_V_dout,
  input  logic               acc_V_empty_n,
  output logic               acc_V_read,
  input  logic [COEFF_W-1:0] bias_V_dout,
  input  logic               bias_V_empty_n,
  output logic               bias_V_read,
  output logic [OUT_W-1:0]   output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write,
  output logic               frame_done
);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

  state_t              state, state_nxt;
  logic [CH_W-1:0]     ch_cnt, ch_nxt;
  logic [PIX_W-1:0]    pix_cnt, pix_nxt;
  logic                out_valid;
  logic [OUT_W-1:0]    out_data;
  logic                bias_pop;
  logic                accept;
  logic                transfer;
  logic                drain_done;
  logic [COEFF_W-1:0]  bias_rdata;
  logic signed [ACC_W:0] acc_ext, bias_ext, sum, shifted;

  bias_regfile_13 u_regfile (
    .clk   (ap_clk),
    .we    (bias_V_read),
    .waddr (ch_cnt),
    .wdata (bias_V_dout),
    .raddr (ch_cnt),
    .rdata (bias_rdata)
  );

  // Datapath: sign-extend both operands into ACC_W+1 bits, align the bias to
  // the accumulator fixed-point format, add, then rescale arithmetically.
  always_comb begin
    acc_ext  = $signed({acc_V_dout[ACC_W-1], acc_V_dout});
    bias_ext = $signed({{(ACC_W+1-COEFF_W){bias_rdata[COEFF_W-1]}}, bias_rdata}) <<< BIAS_SHL;
    sum      = acc_ext + bias_ext;
    shifted  = sum >>> OUT_SHR;
  end

  assign transfer = out_valid && output_V_full_n;

  // Next-state and counter logic for the LOAD -> RUN -> DRAIN frame cycle.
  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch_cnt;
    pix_nxt    = pix_cnt;
    bias_pop   = 1'b0;
    accept     = 1'b0;
    drain_done = 1'b0;
    case (state)
      LOAD: begin
        if (bias_V_empty_n) begin
          bias_pop = 1'b1;
          if (ch_cnt == CH_LAST) begin
            ch_nxt    = '0;
            state_nxt = RUN;
          end else begin
            ch_nxt = ch_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        // A new word may enter only if the output register is free or is
        // being emptied this same cycle.
        if (acc_V_empty_n && (!out_valid || output_V_full_n)) begin
          accept = 1'b1;
          if (ch_cnt == CH_LAST) begin
            ch_nxt = '0;
            if (pix_cnt == PIX_LAST) begin
              pix_nxt   = '0;
              state_nxt = DRAIN;
            end else begin
              pix_nxt = pix_cnt + 1'b1;
            end
          end else begin
            ch_nxt = ch_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (transfer) begin
          drain_done = 1'b1;
          state_nxt  = LOAD;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  // FIFO strobes are masked while reset is held so no word is popped from an
  // upstream FIFO that this block will then discard.
  assign bias_V_read    = bias_pop && ap_rst_n;
  assign acc_V_read     = accept && ap_rst_n;
  assign frame_done     = drain_done && ap_rst_n;
  assign output_V_write = out_valid;
  assign output_V_din   = out_data;

  // State, counters and the single-entry output register. Accept has
  // priority over transfer so back-to-back words stream at one per cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= LOAD;
      ch_cnt    <= '0;
      pix_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state   <= state_nxt;
      ch_cnt  <= ch_nxt;
      pix_cnt <= pix_nxt;
      if (accept) begin
        out_data  <= narrow_result(shifted);
        out_valid <= 1'b1;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_add_13.sv
// tb_bias_add_13
//   Self-checking bench for bias_add_13. FIFO models feed the bias and
//   accumulator ports; every accumulator word pushed carries its expected
//   result into a scoreboard queue that is compared when the DUT pushes.
//   Honours BIAS_ADD_13_SAT_EN for the saturation-dependent expectations.
module tb_bias_add_13;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [31:0] acc_V_dout = '0;
  logic        acc_V_empty_n = 1'b0;
  logic        acc_V_read;
  logic [15:0] bias_V_dout = '0;
  logic        bias_V_empty_n = 1'b0;
  logic        bias_V_read;
  logic [15:0] output_V_din;
  logic        output_V_full_n = 1'b1;
  logic        output_V_write;
  logic        frame_done;

  bias_add_13 dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .acc_V_dout      (acc_V_dout),
    .acc_V_empty_n   (acc_V_empty_n),
    .acc_V_read      (acc_V_read),
    .bias_V_dout     (bias_V_dout),
    .bias_V_empty_n  (bias_V_empty_n),
    .bias_V_read     (bias_V_read),
    .output_V_din    (output_V_din),
    .output_V_full_n (output_V_full_n),
    .output_V_write  (output_V_write),
    .frame_done      (frame_done)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0] acc;
    logic [15:0] bias;
    logic [15:0] exp_out;
  } vec_t;

`ifdef BIAS_ADD_13_SAT_EN
  localparam logic [15:0] EXP_BIG_POS = 16'h7FFF;
  localparam logic [15:0] EXP_JUST_OVER = 16'h7FFF;
`else
  localparam logic [15:0] EXP_BIG_POS = 16'h7EFF;
  localparam logic [15:0] EXP_JUST_OVER = 16'h8000;
`endif

  logic [31:0] acc_q [$];
  logic [15:0] bias_q [$];
  logic [15:0] exp_q [$];

  int   n_compared = 0;
  int   n_mismatched = 0;
  int   writes = 0;
  int   fd_cnt = 0;
  int   fd_at = 0;
  int   bias_pops = 0;
  logic out_hold = 1'b0;
  logic lat_pend = 1'b0;

  // Reference arithmetic in wide integers, independent of the RTL datapath.
  function automatic logic [15:0] model(input logic [31:0] acc, input logic [15:0] bias);
    longint s;
    longint r;
    s = longint'($signed(acc)) + longint'($signed(bias)) * 256;
    r = s >>> 8;
`ifdef BIAS_ADD_13_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNote(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: condition not met at %0t", name, $time);
  endtask

  task automatic applyStimulus(input logic [31:0] acc, input logic [15:0] expected);
    acc_q.push_back(acc);
    exp_q.push_back(expected);
  endtask

  task automatic waitWrites(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge ap_clk);
      #2;
      if (writes >= target) break;
    end
    if (writes < target) failNote("wait_writes_timeout");
  endtask

  task automatic waitFrameDone(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge ap_clk);
      #2;
      if (fd_cnt >= target) break;
    end
    if (fd_cnt < target) failNote("wait_frame_done_timeout");
  endtask

  task automatic waitBiasEmpty(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge ap_clk);
      #2;
      if (bias_q.size() == 0) break;
    end
    if (bias_q.size() != 0) failNote("wait_bias_empty_timeout");
  endtask

  // FIFO agent: drive inputs on the falling edge, then observe the strobes
  // and settle the transfers that the next rising edge will commit.
  always begin
    @(negedge ap_clk);
    bias_V_empty_n = (bias_q.size() > 0);
    if (bias_q.size() > 0) bias_V_dout = bias_q[0];
    acc_V_empty_n = (acc_q.size() > 0);
    if (acc_q.size() > 0) acc_V_dout = acc_q[0];
    output_V_full_n = !out_hold;
    #1;
    if (!ap_rst_n) begin
      lat_pend = 1'b0;
    end else if (lat_pend) begin
      checkOutput("latency_write", 32'(output_V_write), 32'd1);
      lat_pend = 1'b0;
    end
    if (bias_V_read) begin
      if (bias_q.size() > 0) void'(bias_q.pop_front());
      else failNote("bias_pop_while_empty");
      bias_pops++;
    end
    if (acc_V_read) begin
      if (acc_q.size() > 0) void'(acc_q.pop_front());
      else failNote("acc_pop_while_empty");
      lat_pend = 1'b1;
    end
    if (output_V_write && output_V_full_n) begin
      writes++;
      if (exp_q.size() == 0) failNote("unexpected_write");
      else checkOutput("dout", 32'(output_V_din), 32'(exp_q.pop_front()));
      if (frame_done) begin
        fd_cnt++;
        fd_at = writes;
      end
    end else if (frame_done) begin
      failNote("frame_done_without_push");
    end
  end

  initial begin
    vec_t        tbl [16];
    logic [15:0] fresh [16];
    logic [15:0] held;
    logic [31:0] a;
    int          wbase;
    int          bsnap;

    tbl[0] = '{32'h0000_0000, 16'h0000, 16'h0000};
    tbl[1] = '{32'h7FFF_0000, 16'h7FFF, EXP_BIG_POS};
    tbl[2] = '{32'hFFFF_FF00, 16'hFFFF, 16'hFFFE};
    tbl[3] = '{32'h0000_1234, 16'h0005, 16'h0017};
    tbl[4] = '{32'h8000_0000, 16'h8000, 16'h8000};
    tbl[5] = '{32'hFFFF_FFFF, 16'h0000, 16'hFFFF};
    tbl[6] = '{32'h007F_FF00, 16'h0000, 16'h7FFF};
    tbl[7] = '{32'h0080_0000, 16'h0000, EXP_JUST_OVER};
    tbl[8] = '{32'hFF80_0000, 16'h0000, 16'h8000};
    tbl[9] = '{32'h0000_0010, 16'h0001, 16'h0001};
    for (int k = 10; k < 16; k++) tbl[k] = '{32'(k * 256), 16'(-k), 16'h0000};

    // Reset state, with bias words already waiting.
    for (int k = 0; k < 16; k++) bias_q.push_back(16'(k));
    repeat (2) @(negedge ap_clk);
    #2;
    checkOutput("rst_bias_read", 32'(bias_V_read), 32'd0);
    checkOutput("rst_acc_read", 32'(acc_V_read), 32'd0);
    checkOutput("rst_write", 32'(output_V_write), 32'd0);
    checkOutput("rst_din", 32'(output_V_din), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    // Frame 1: biases 0..15, zero accumulators, with a 5-cycle output stall.
    $display("[TB] frame 1: ramp biases, output stall");
    for (int p = 0; p < 64; p++)
      for (int c = 0; c < 16; c++) applyStimulus(32'd0, 16'(c));
    waitWrites(300, 2000);
    out_hold = 1'b1;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      #2;
      if (i == 0) begin
        held = output_V_din;
        checkOutput("stall_head", 32'(held), 32'(exp_q[0]));
      end else begin
        checkOutput("stall_hold", 32'(output_V_din), 32'(held));
      end
      checkOutput("stall_no_read", 32'(acc_V_read), 32'd0);
      checkOutput("stall_write", 32'(output_V_write), 32'd1);
    end
    out_hold = 1'b0;
    waitFrameDone(1, 3000);
    checkOutput("f1_writes", 32'(writes), 32'd1024);
    checkOutput("f1_done_at", 32'(fd_at), 32'd1024);
    checkOutput("f1_done_cnt", 32'(fd_cnt), 32'd1);

    // Frame 2: vector table on pixel 0, random accumulators after; the bias
    // FIFO runs dry after four coefficients.
    $display("[TB] frame 2: vector table, bias underrun");
    for (int c = 0; c < 16; c++) applyStimulus(tbl[c].acc, tbl[c].exp_out);
    for (int p = 1; p < 64; p++)
      for (int c = 0; c < 16; c++) begin
        a = $urandom();
        applyStimulus(a, model(a, tbl[c].bias));
      end
    for (int c = 0; c < 4; c++) bias_q.push_back(tbl[c].bias);
    for (int i = 0; i < 7; i++) begin
      @(negedge ap_clk);
      #2;
      checkOutput("underrun_no_acc_read", 32'(acc_V_read), 32'd0);
    end
    for (int c = 4; c < 16; c++) bias_q.push_back(tbl[c].bias);
    waitFrameDone(2, 3000);
    checkOutput("f2_writes", 32'(writes), 32'd2048);
    checkOutput("f2_done_at", 32'(fd_at), 32'd2048);

    // Frame 3 is abandoned by a reset pulse in the middle of RUN.
    $display("[TB] frame 3: reset mid-run");
    for (int c = 0; c < 16; c++) bias_q.push_back(16'(7 * c - 50));
    for (int i = 0; i < 300; i++) begin
      a = $urandom();
      applyStimulus(a, model(a, 16'(7 * (i % 16) - 50)));
    end
    waitWrites(2048 + 50, 1000);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    bsnap = bias_pops;
    #1;
    checkOutput("mid_rst_write", 32'(output_V_write), 32'd0);
    checkOutput("mid_rst_din", 32'(output_V_din), 32'd0);
    checkOutput("mid_rst_acc_read", 32'(acc_V_read), 32'd0);
    checkOutput("mid_rst_frame_done", 32'(frame_done), 32'd0);
    acc_q.delete();
    bias_q.delete();
    exp_q.delete();
    for (int c = 0; c < 16; c++) begin
      fresh[c] = 16'(1000 - 37 * c);
      bias_q.push_back(fresh[c]);
    end
    @(negedge ap_clk);
    #2;
    checkOutput("mid_rst_bias_read", 32'(bias_V_read), 32'd0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    // Frame 4: fresh biases reloaded; next frame's biases wait untouched.
    $display("[TB] frame 4: after reset");
    waitBiasEmpty(100);
    checkOutput("reload_bias_pops", 32'(bias_pops - bsnap), 32'd16);
    for (int c = 0; c < 16; c++) bias_q.push_back(16'h1111);
    wbase = writes;
    for (int p = 0; p < 64; p++)
      for (int c = 0; c < 16; c++) begin
        a = $urandom();
        applyStimulus(a, model(a, fresh[c]));
      end
    waitFrameDone(3, 3000);
    checkOutput("f4_bias_untouched", 32'(bias_q.size()), 32'd16);
    checkOutput("f4_writes", 32'(writes - wbase), 32'd1024);
    checkOutput("f4_done_at", 32'(fd_at), 32'(wbase + 1024));
    repeat (4) @(negedge ap_clk);
    #2;
    checkOutput("final_done_cnt", 32'(fd_cnt), 32'd3);
    checkOutput("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
